// File: rtl/signal_edge_detector.sv
`default_nettype none
// ---------------------------------------------------------------------------
// signal_edge_detector : per-bit same-cycle rise/fall pulse generator
// Revision 1.0
// ---------------------------------------------------------------------------
module signal_edge_detector #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] any_edge
);

  // prev keeps following in during reset so release never fires a stale edge
  logic [WIDTH-1:0] prev_q = '0;
  logic [WIDTH-1:0] prev_d;
  logic [WIDTH-1:0] w_enable;

  always_comb begin
    prev_d   = in;
    w_enable = {WIDTH{~reset}};
    rise     = in & ~prev_q & w_enable;
    fall     = ~in & prev_q & w_enable;
    any_edge = rise | fall;
  end

  always_ff @(posedge clk) begin
    prev_q <= prev_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_signal_edge_detector.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_signal_edge_detector : table-driven and scoreboard checks for the detector
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_signal_edge_detector;

  typedef struct {
    logic rst;
    logic din;
    logic rise;
    logic fall;
  } vec1_t;

  typedef struct {
    logic       rst;
    logic [3:0] din;
    logic [3:0] rise;
    logic [3:0] fall;
  } vec4_t;

  typedef struct {
    logic [3:0] rise;
    logic [3:0] fall;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1 = 1'b0;
  logic [0:0] in1  = 1'b0;
  logic [0:0] rise1, fall1, any1;

  logic       rst4 = 1'b0;
  logic [3:0] in4  = 4'b0000;
  logic [3:0] rise4, fall4, any4;

  logic       rst_pu = 1'b0;
  logic [0:0] in_pu  = 1'b1;
  logic [0:0] rise_pu, fall_pu, any_pu;

  signal_edge_detector #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(rst1), .in(in1), .rise(rise1), .fall(fall1), .any_edge(any1)
  );

  signal_edge_detector #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(rst4), .in(in4), .rise(rise4), .fall(fall4), .any_edge(any4)
  );

  signal_edge_detector #(.WIDTH(1)) dut_pu (
    .clk(clk), .reset(rst_pu), .in(in_pu), .rise(rise_pu), .fall(fall_pu), .any_edge(any_pu)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec1_t v1[$];
  vec4_t v4[$];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive just after posedge, queue the expectation, compare at the next negedge
  task automatic step1(input vec1_t v, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    rst1 = v.rst;
    in1  = v.din;
    sb.push_back('{rise: {3'b000, v.rise}, fall: {3'b000, v.fall}});
    @(negedge clk);
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 4'b0001, 4'b0000);
    end else begin
      e = sb.pop_front();
      chk({name, "_rise"}, {3'b000, rise1}, e.rise);
      chk({name, "_fall"}, {3'b000, fall1}, e.fall);
      chk({name, "_any"},  {3'b000, any1},  e.rise | e.fall);
    end
  endtask

  task automatic step4(input vec4_t v, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    rst4 = v.rst;
    in4  = v.din;
    sb.push_back('{rise: v.rise, fall: v.fall});
    @(negedge clk);
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 4'b0001, 4'b0000);
    end else begin
      e = sb.pop_front();
      chk({name, "_rise"}, rise4, e.rise);
      chk({name, "_fall"}, fall4, e.fall);
      chk({name, "_any"},  any4,  e.rise | e.fall);
    end
  endtask

  initial begin : main
    logic [3:0] model_prev;
    logic [3:0] r_in;
    logic       r_rst;
    logic [3:0] er;
    logic [3:0] ef;

    // Power-up without reset: input already high before the first posedge
    #2;
    chk("pu_first_rise", {3'b000, rise_pu}, 4'b0001);
    chk("pu_first_fall", {3'b000, fall_pu}, 4'b0000);
    repeat (3) begin
      @(negedge clk);
      chk("pu_held_rise", {3'b000, rise_pu}, 4'b0000);
    end

    // Reset held with in high, then released with in still high
    repeat (3) v1.push_back('{rst: 1'b1, din: 1'b1, rise: 1'b0, fall: 1'b0});
    repeat (3) v1.push_back('{rst: 1'b0, din: 1'b1, rise: 1'b0, fall: 1'b0});
    // Dropping to 0 after the held-high phase is itself a fall
    v1.push_back('{rst: 1'b0, din: 1'b0, rise: 1'b0, fall: 1'b1});
    // Sequence 0,0,1,1,1,0,0
    v1.push_back('{rst: 1'b0, din: 1'b0, rise: 1'b0, fall: 1'b0});
    v1.push_back('{rst: 1'b0, din: 1'b0, rise: 1'b0, fall: 1'b0});
    v1.push_back('{rst: 1'b0, din: 1'b1, rise: 1'b1, fall: 1'b0});
    v1.push_back('{rst: 1'b0, din: 1'b1, rise: 1'b0, fall: 1'b0});
    v1.push_back('{rst: 1'b0, din: 1'b1, rise: 1'b0, fall: 1'b0});
    v1.push_back('{rst: 1'b0, din: 1'b0, rise: 1'b0, fall: 1'b1});
    v1.push_back('{rst: 1'b0, din: 1'b0, rise: 1'b0, fall: 1'b0});
    // Toggle every cycle for 8 cycles, starting from 0
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) v1.push_back('{rst: 1'b0, din: 1'b1, rise: 1'b1, fall: 1'b0});
      else            v1.push_back('{rst: 1'b0, din: 1'b0, rise: 1'b0, fall: 1'b1});
    end
    // Rising edge coincident with reset is masked and not replayed after release
    v1.push_back('{rst: 1'b1, din: 1'b1, rise: 1'b0, fall: 1'b0});
    v1.push_back('{rst: 1'b0, din: 1'b1, rise: 1'b0, fall: 1'b0});
    v1.push_back('{rst: 1'b0, din: 1'b1, rise: 1'b0, fall: 1'b0});
    // Falling edge under reset is masked too
    v1.push_back('{rst: 1'b1, din: 1'b0, rise: 1'b0, fall: 1'b0});
    v1.push_back('{rst: 1'b0, din: 1'b0, rise: 1'b0, fall: 1'b0});

    foreach (v1[k]) step1(v1[k], $sformatf("w1_v%0d", k));

    // Wide vectors: independent bits
    v4.push_back('{rst: 1'b0, din: 4'b0000, rise: 4'b0000, fall: 4'b0000});
    v4.push_back('{rst: 1'b0, din: 4'b0101, rise: 4'b0101, fall: 4'b0000});
    v4.push_back('{rst: 1'b0, din: 4'b0011, rise: 4'b0010, fall: 4'b0100});
    v4.push_back('{rst: 1'b0, din: 4'b1100, rise: 4'b1100, fall: 4'b0011});
    v4.push_back('{rst: 1'b0, din: 4'b1100, rise: 4'b0000, fall: 4'b0000});
    v4.push_back('{rst: 1'b1, din: 4'b0011, rise: 4'b0000, fall: 4'b0000});
    v4.push_back('{rst: 1'b0, din: 4'b0011, rise: 4'b0000, fall: 4'b0000});

    foreach (v4[k]) step4(v4[k], $sformatf("w4_v%0d", k));

    // Random traffic against a reference model of the previous sample
    model_prev = 4'b0011;
    for (int k = 0; k < 40; k++) begin
      r_in  = 4'($urandom_range(0, 15));
      r_rst = ($urandom_range(0, 7) == 0);
      er = r_in & ~model_prev & {4{~r_rst}};
      ef = ~r_in & model_prev & {4{~r_rst}};
      step4('{rst: r_rst, din: r_in, rise: er, fall: ef}, $sformatf("w4_rand%0d", k));
      chk($sformatf("w4_rand%0d_overlap", k), rise4 & fall4, 4'b0000);
      model_prev = r_in;
    end

    if (sb.size() != 0) chk("sb_leftover", 4'(sb.size()), 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
